read_from_zbt: RTL
==================

// Module: read_from_zbt
// PURPOSE
//  Streaming reader for packed 3-D points stored in ZBT SRAM by the write path.
//  On start, issues sequential reads from base_addr for num_points words.
//  Unpacks each returned 36-bit word into x/y/z 10-bit fields.
//  Presents the fields on a valid/ready stream toward the display/mesh logic,
//  with a small FIFO absorbing the SRAM read latency under backpressure.
// PARAMETERS
//  ADDR_W      19  SRAM word address width
//  DATA_W      36  SRAM word width
//  READ_LAT     2  cycles from read_addr/read_en to read_data valid (ZBT pipeline)
//  FIFO_DEPTH   4  output FIFO entries; must be >= READ_LAT+1, power of two
// PORTS
//  clk         in   1       system clock
//  reset       in   1       synchronous, active-high
//  start       in   1       one-cycle pulse; latches base_addr/num_points when idle
//  base_addr   in   ADDR_W  first word address
//  num_points  in   ADDR_W  words to read; 0 is legal
//  read_en     out  1       read request to ZBT controller this cycle
//  read_addr   out  ADDR_W  address for read_en
//  read_data   in   DATA_W  SRAM data, valid READ_LAT cycles after read_en
//  pt_valid    out  1       point available on pt_x/pt_y/pt_z
//  pt_ready    in   1       consumer accepts point when pt_valid&pt_ready
//  pt_x        out  10      read_data[29:20]
//  pt_y        out  10      read_data[19:10]
//  pt_z        out  10      read_data[9:0]
//  busy        out  1       high from accepted start until done pulse
//  done        out  1       one-cycle pulse: last point accepted by consumer
// BEHAVIOUR
//  Reset: read_en=0, read_addr=0, pt_valid=0, pt_x/y/z=0, busy=0, done=0;
//   FIFO emptied, in-flight shift register cleared, FSM to IDLE.
//  FSM: IDLE -> (start) ISSUE -> (all reads issued) DRAIN -> (FIFO empty,
//   nothing in flight) DONE -> IDLE. DONE lasts one cycle; done=1 there.
//  start in IDLE with num_points=0: go straight to DONE, no read_en.
//  start while busy: ignored, latched parameters unchanged.
//  ISSUE: read_en=1 only when fifo_count + in_flight < FIFO_DEPTH (credit rule);
//   in_flight counts reads issued but not yet returned (0..READ_LAT).
//  read_addr increments by 1 per issued read, wraps 2^ADDR_W-1 -> 0.
//  Remaining counter decrements per issued read; last read leaves ISSUE.
//  Return path: READ_LAT-deep valid shift register of read_en; at its tail,
//   read_data[29:0] pushed into FIFO. read_data[35:30] ignored.
//  FIFO never overflows by credit rule; push and pop in same cycle legal.
//  Output: pt_valid = FIFO not empty; fields from FIFO head (first-word-fall-
//   through); values hold stable while pt_valid & !pt_ready.
//  Peak throughput 1 point/clk with pt_ready held high.
//  Total latency start -> first pt_valid = 1 + READ_LAT cycles (+1 FIFO write).
//  Reset mid-operation: all state cleared; data returning afterwards dropped.
// STRUCTURE
//  Shared package/header: ZBT_ADDR_W, ZBT_DATA_W, ZBT_READ_LAT, point field
//   slices PT_X_MSB/LSB, PT_Y_MSB/LSB, PT_Z_MSB/LSB (same as write path).
//  One sub-module: zbt_point_fifo (sync FIFO, 30-bit, FWFT, count output).
//  FSM, issue counter, in-flight tracker remain in this module.
// TESTING
//  Bench models ZBT read with READ_LAT=2 pipeline over a preloaded array.
//  1) word 0 = {6'b0,10'd100,10'd100,10'h3FC}; start base=0,n=1, ready=1
//     -> pt_x=100,pt_y=100,pt_z=1020 once, done pulse, busy low after.
//  2) base=16,n=8, ready=1 -> read_addr 16..23 consecutive, 8 points in order,
//     one per cycle after latency, exactly one done.
//  3) base=16,n=8, ready toggled 1-of-3 -> no lost/duplicated points, read_en
//     stalls, pt_* stable while stalled, fifo never exceeds 4.
//  4) base=2^19-2,n=4 -> addresses 7FFFE,7FFFF,00000,00001.
//  5) n=0 -> done one cycle after start, read_en never asserted; start during
//     busy ignored.
//  6) reset asserted 3 cycles into n=8 read -> all outputs to reset values next
//     cycle; no pt_valid from stale returns; fresh start works normally.

Source files
------------

// File: rtl/read_from_zbt_pkg.sv
// Shared constants and types for the ZBT point reader (same field layout as the write path).
package read_from_zbt_pkg;

  localparam int unsigned ZBT_ADDR_W     = 19;
  localparam int unsigned ZBT_DATA_W     = 36;
  localparam int unsigned ZBT_READ_LAT   = 2;
  localparam int unsigned ZBT_FIFO_DEPTH = 4;

  localparam int unsigned PT_W    = 10;
  localparam int unsigned PT_BITS = 3 * PT_W;

  localparam int unsigned PT_X_MSB = 29;
  localparam int unsigned PT_X_LSB = 20;
  localparam int unsigned PT_Y_MSB = 19;
  localparam int unsigned PT_Y_LSB = 10;
  localparam int unsigned PT_Z_MSB = 9;
  localparam int unsigned PT_Z_LSB = 0;

  // Packed so that {x, y, z} lines up bit-for-bit with word[PT_X_MSB:PT_Z_LSB].
  typedef struct packed {
    logic [PT_W-1:0] x;
    logic [PT_W-1:0] y;
    logic [PT_W-1:0] z;
  } point_t;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } zbt_rd_state_e;

endpackage

// File: rtl/read_from_zbt_if.sv
// Control, SRAM read and point-stream signals of the ZBT point reader.
interface read_from_zbt_if
  import read_from_zbt_pkg::*;
#(
  parameter int unsigned ADDR_W = ZBT_ADDR_W,
  parameter int unsigned DATA_W = ZBT_DATA_W
);

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] num_points;
  logic              busy;
  logic              done;

  logic              read_en;
  logic [ADDR_W-1:0] read_addr;
  logic [DATA_W-1:0] read_data;

  logic              pt_valid;
  logic              pt_ready;
  logic [PT_W-1:0]   pt_x;
  logic [PT_W-1:0]   pt_y;
  logic [PT_W-1:0]   pt_z;

  // Reader side.
  modport master (
    input  start, base_addr, num_points, read_data, pt_ready,
    output busy, done, read_en, read_addr, pt_valid, pt_x, pt_y, pt_z
  );

  // Environment side: SRAM controller, control logic and point consumer.
  modport slave (
    output start, base_addr, num_points, read_data, pt_ready,
    input  busy, done, read_en, read_addr, pt_valid, pt_x, pt_y, pt_z
  );

endinterface

// File: rtl/zbt_point_fifo.sv
// Small synchronous first-word-fall-through FIFO for unpacked points, with occupancy count.
module zbt_point_fifo #(
  parameter int unsigned WIDTH = 30,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic            pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             full, do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == CntW'(DEPTH));
  assign do_push = push_i && !full;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

  // Pointer and occupancy next-state; DEPTH is a power of two so pointers wrap for free.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + PtrW'(1);
    if (do_pop)  rptr_d = rptr_q + PtrW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array; contents are don't-care while empty so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  // Pointer and count registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/read_from_zbt.sv
// Streams packed 3-D points out of ZBT SRAM: issues credit-limited sequential reads and
// unpacks returned words into an x/y/z valid/ready stream through a small FIFO.
module read_from_zbt
  import read_from_zbt_pkg::*;
#(
  parameter int unsigned ADDR_W     = ZBT_ADDR_W,
  parameter int unsigned DATA_W     = ZBT_DATA_W,
  parameter int unsigned READ_LAT   = ZBT_READ_LAT,
  parameter int unsigned FIFO_DEPTH = ZBT_FIFO_DEPTH
) (
  input  logic           clk,
  input  logic           reset,
  read_from_zbt_if.master bus
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned LatW = $clog2(READ_LAT + 1);
  localparam int unsigned SumW = CntW + 1;

  zbt_rd_state_e       state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   rem_q, rem_d;
  logic [READ_LAT-1:0] vld_sr_q, vld_sr_d;

  logic [LatW-1:0]     in_flight;
  logic [CntW-1:0]     fifo_count;
  logic [SumW-1:0]     credit_used;
  logic                credit_ok;
  logic                issue;
  logic                busy, done;
  logic                fifo_empty, pop;
  point_t              head;

  // Top bits of the SRAM word carry nothing for the display path.
  logic unused_read_data_hi;
  assign unused_read_data_hi = ^bus.read_data[DATA_W-1:PT_X_MSB+1];

  // Count reads issued but not yet returned.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < READ_LAT; i++) begin
      in_flight = in_flight + LatW'(vld_sr_q[i]);
    end
  end

  // Only issue while every outstanding word is guaranteed a FIFO slot.
  assign credit_used = SumW'(fifo_count) + SumW'(in_flight);
  assign credit_ok   = credit_used < SumW'(FIFO_DEPTH);

  // Return-path valid tracker: a copy of read_en delayed by the SRAM pipeline.
  always_comb begin
    vld_sr_d    = vld_sr_q << 1;
    vld_sr_d[0] = issue;
  end

  // FSM next-state, issue counter and control outputs.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    issue   = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (bus.start) begin
          addr_d  = bus.base_addr;
          rem_d   = bus.num_points;
          state_d = (bus.num_points == '0) ? StDone : StIssue;
        end
      end
      StIssue: begin
        if (credit_ok) begin
          issue  = 1'b1;
          addr_d = addr_q + ADDR_W'(1);
          rem_d  = rem_q - ADDR_W'(1);
          if (rem_q == ADDR_W'(1)) state_d = StDrain;
        end
      end
      StDrain: begin
        if (fifo_empty && (in_flight == '0)) state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset also drops any reads still in the SRAM pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      rem_q    <= '0;
      vld_sr_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      vld_sr_q <= vld_sr_d;
    end
  end

  assign pop = !fifo_empty && bus.pt_ready;

  zbt_point_fifo #(
    .WIDTH (PT_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (vld_sr_q[READ_LAT-1]),
    .wdata_i (bus.read_data[PT_X_MSB:PT_Z_LSB]),
    .pop_i   (pop),
    .rdata_o (head),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign bus.read_en   = issue;
  assign bus.read_addr = addr_q;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.pt_valid  = !fifo_empty;
  // Fields read as zero when nothing is presented, so stale FIFO contents never show.
  assign bus.pt_x      = fifo_empty ? '0 : head.x;
  assign bus.pt_y      = fifo_empty ? '0 : head.y;
  assign bus.pt_z      = fifo_empty ? '0 : head.z;

endmodule
